// File: rtl/lif_neuron_cell.sv
// lif_neuron_cell: leaky integrate-and-fire neuron with serial config chain, refractory period and spike counter
module lif_neuron_cell #(
    parameter int N_IN        = 4,
    parameter int W_BITS      = 3,
    parameter int MP_BITS     = 6,
    parameter int N_CLK       = 8,
    parameter int REFRAC_BITS = 2,
    parameter int SEL_BITS    = (N_CLK > 1) ? $clog2(N_CLK) : 1,
    parameter int CFG_LEN     = N_IN * W_BITS + MP_BITS + SEL_BITS + REFRAC_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reset_nn,
    input  logic               config_en,
    input  logic               bs_in,
    output logic               bs_out,
    input  logic [N_CLK-1:0]   clockbus,
    input  logic [N_IN-1:0]    syn_in,
    output logic               axon,
    output logic [MP_BITS-1:0] membrane,
    output logic [7:0]         spike_count
);
    localparam int SUM_BITS = MP_BITS + W_BITS + $clog2(N_IN) + 1;
    typedef enum logic {INTEGRATE, REFRACT} state_t;
    state_t                 state_q, state_d;
    logic [CFG_LEN-1:0]     cfg_q, cfg_d;
    logic [MP_BITS-1:0]     mem_q, mem_d;
    logic [REFRAC_BITS-1:0] cnt_q, cnt_d;
    logic                   axon_q, axon_d;
    logic [7:0]             sc_q, sc_d;
    logic [MP_BITS-1:0]     thr, v_dec, v_next;
    logic [SEL_BITS-1:0]    dsel;
    logic [REFRAC_BITS-1:0] refrac;
    logic [SUM_BITS-1:0]    sum, v_sum;
    logic                   decay, fire;
    assign thr         = cfg_q[N_IN*W_BITS +: MP_BITS];
    assign dsel        = cfg_q[N_IN*W_BITS+MP_BITS +: SEL_BITS];
    assign refrac      = cfg_q[CFG_LEN-1 -: REFRAC_BITS];
    assign bs_out      = cfg_q[0];
    assign axon        = axon_q;
    assign membrane    = mem_q;
    assign spike_count = sc_q;
    // Candidate membrane value: leak, add signed synaptic sum, clamp to [0, 2^MP_BITS-1]
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++)
            if (syn_in[i]) sum = sum + SUM_BITS'(signed'(cfg_q[i*W_BITS +: W_BITS]));
        decay  = (32'(dsel) < N_CLK) ? clockbus[dsel] : 1'b0;
        v_dec  = decay ? (mem_q >> 1) : mem_q;
        v_sum  = {{(SUM_BITS-MP_BITS){1'b0}}, v_dec} + sum;
        v_next = v_sum[SUM_BITS-1] ? '0 : (|v_sum[SUM_BITS-2:MP_BITS]) ? '1 : v_sum[MP_BITS-1:0];
        fire   = v_next >= thr;
    end
    // Next-state: network reset, config shift (dynamic state frozen), integrate/fire or refractory countdown
    always_comb begin
        cfg_d   = cfg_q;
        mem_d   = mem_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        sc_d    = sc_q;
        axon_d  = 1'b0;
        if (reset_nn) begin
            mem_d   = '0;
            state_d = INTEGRATE;
            cnt_d   = '0;
            sc_d    = '0;
        end else if (config_en) begin
            cfg_d = {bs_in, cfg_q[CFG_LEN-1:1]};
        end else if (state_q == INTEGRATE) begin
            if (fire) begin
                axon_d  = 1'b1;
                mem_d   = '0;
                sc_d    = (sc_q == 8'hFF) ? sc_q : sc_q + 8'd1;
                state_d = (refrac == '0) ? INTEGRATE : REFRACT;
                cnt_d   = refrac;
            end else begin
                mem_d = v_next;
            end
        end else begin
            mem_d   = '0;
            cnt_d   = cnt_q - REFRAC_BITS'(1);
            state_d = (cnt_q <= REFRAC_BITS'(1)) ? INTEGRATE : REFRACT;
        end
    end
    // State registers with synchronous full reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q   <= '0;
            mem_q   <= '0;
            state_q <= INTEGRATE;
            cnt_q   <= '0;
            axon_q  <= 1'b0;
            sc_q    <= '0;
        end else begin
            cfg_q   <= cfg_d;
            mem_q   <= mem_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            axon_q  <= axon_d;
            sc_q    <= sc_d;
        end
    end
endmodule

// File: tb/tb_lif_neuron_cell.sv
// tb_lif_neuron_cell: directed table-driven bench for lif_neuron_cell with hand-written corner sequences
module tb_lif_neuron_cell;
    logic       clk = 1'b0;
    logic       reset, reset_nn, config_en, bs_in, bs_out, axon;
    logic [7:0] clockbus;
    logic [3:0] syn_in;
    logic [5:0] membrane;
    logic [7:0] spike_count;
    int         n_cmp = 0;
    int         n_bad = 0;

    lif_neuron_cell dut (
        .clk(clk), .reset(reset), .reset_nn(reset_nn), .config_en(config_en),
        .bs_in(bs_in), .bs_out(bs_out), .clockbus(clockbus), .syn_in(syn_in),
        .axon(axon), .membrane(membrane), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [22:0] cfg;
        logic [3:0]  syn;
        logic [7:0]  cb;
        logic        nn;
        logic [5:0]  mem;
        logic        ax;
        logic [7:0]  sc;
    } vec_t;
    vec_t tv[$];

    function automatic logic [22:0] cfgw(logic [2:0] w0, logic [2:0] w1, logic [2:0] w2, logic [2:0] w3,
                                         logic [5:0] thr, logic [2:0] dsel, logic [1:0] rf);
        return {rf, dsel, thr, w3, w2, w1, w0};
    endfunction

    function automatic vec_t mk(logic ld, logic [22:0] cfg, logic [3:0] syn, logic [7:0] cb, logic nn,
                                logic [5:0] mem, logic ax, logic [7:0] sc);
        vec_t v;
        v = '{ld, cfg, syn, cb, nn, mem, ax, sc};
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(logic [22:0] c);
        config_en = 1'b1;
        for (int i = 0; i < 23; i++) begin
            bs_in = c[i];
            step();
        end
        config_en = 1'b0;
        bs_in = 1'b0;
    endtask

    task automatic chk_out(string tag, logic [5:0] mem, logic ax, logic [7:0] sc);
        chk({tag, ".membrane"}, int'(membrane), int'(mem));
        chk({tag, ".axon"}, int'(axon), int'(ax));
        chk({tag, ".spike_count"}, int'(spike_count), int'(sc));
    endtask

    initial begin
        logic [22:0] pat, c1, c2, c3, c4, c5;
        c1 = cfgw(3'd3, 3'd0, 3'd0, 3'd0, 6'd9, 3'd0, 2'd0);
        c2 = cfgw(3'd0, 3'b100, 3'd0, 3'd0, 6'd63, 3'd0, 2'd0);
        c3 = cfgw(3'd3, 3'd3, 3'd3, 3'd3, 6'd63, 3'd0, 2'd0);
        c4 = cfgw(3'd2, 3'd0, 3'd0, 3'd0, 6'd63, 3'd1, 2'd0);
        c5 = cfgw(3'd3, 3'd0, 3'd0, 3'd0, 6'd3, 3'd0, 2'd2);
        // integrate / fire, refrac 0
        tv.push_back(mk(1, c1, 4'h0, 8'h00, 1, 0, 0, 0));
        tv.push_back(mk(0, c1, 4'h1, 8'h00, 0, 3, 0, 0));
        tv.push_back(mk(0, c1, 4'h1, 8'h00, 0, 6, 0, 0));
        tv.push_back(mk(0, c1, 4'h1, 8'h00, 0, 0, 1, 1));
        tv.push_back(mk(0, c1, 4'h1, 8'h00, 0, 3, 0, 1));
        tv.push_back(mk(0, c1, 4'h1, 8'h00, 0, 6, 0, 1));
        tv.push_back(mk(0, c1, 4'h1, 8'h00, 0, 0, 1, 2));
        // inhibition never goes negative
        tv.push_back(mk(1, c2, 4'h0, 8'h00, 1, 0, 0, 0));
        tv.push_back(mk(0, c2, 4'h2, 8'h00, 0, 0, 0, 0));
        tv.push_back(mk(0, c2, 4'h2, 8'h00, 0, 0, 0, 0));
        // saturation clamps to 63 and fires
        tv.push_back(mk(1, c3, 4'h0, 8'h00, 1, 0, 0, 0));
        tv.push_back(mk(0, c3, 4'hF, 8'h00, 0, 12, 0, 0));
        tv.push_back(mk(0, c3, 4'hF, 8'h00, 0, 24, 0, 0));
        tv.push_back(mk(0, c3, 4'hF, 8'h00, 0, 36, 0, 0));
        tv.push_back(mk(0, c3, 4'hF, 8'h00, 0, 48, 0, 0));
        tv.push_back(mk(0, c3, 4'hF, 8'h00, 0, 60, 0, 0));
        tv.push_back(mk(0, c3, 4'hF, 8'h00, 0, 0, 1, 1));
        // leak via clockbus[1], then strobe low
        tv.push_back(mk(1, c4, 4'h0, 8'h00, 1, 0, 0, 0));
        tv.push_back(mk(0, c4, 4'h1, 8'h02, 0, 2, 0, 0));
        tv.push_back(mk(0, c4, 4'h1, 8'h02, 0, 3, 0, 0));
        tv.push_back(mk(0, c4, 4'h1, 8'h02, 0, 3, 0, 0));
        tv.push_back(mk(0, c4, 4'h1, 8'hFE, 0, 3, 0, 0));
        tv.push_back(mk(0, c4, 4'h1, 8'h01, 0, 5, 0, 0));
        tv.push_back(mk(0, c4, 4'h1, 8'h01, 0, 7, 0, 0));
        // refractory period 2: spikes every 3 cycles, syn ignored while refractory
        tv.push_back(mk(1, c5, 4'h0, 8'h00, 1, 0, 0, 0));
        tv.push_back(mk(0, c5, 4'h1, 8'h00, 0, 0, 1, 1));
        tv.push_back(mk(0, c5, 4'h0, 8'hFF, 0, 0, 0, 1));
        tv.push_back(mk(0, c5, 4'hF, 8'h00, 0, 0, 0, 1));
        tv.push_back(mk(0, c5, 4'h1, 8'h00, 0, 0, 1, 2));
        tv.push_back(mk(0, c5, 4'h1, 8'h00, 0, 0, 0, 2));
        tv.push_back(mk(0, c5, 4'h1, 8'h00, 0, 0, 0, 2));
        tv.push_back(mk(0, c5, 4'h1, 8'h00, 0, 0, 1, 3));

        reset = 1'b1; reset_nn = 1'b0; config_en = 1'b1; bs_in = 1'b0;
        clockbus = '0; syn_in = '0;
        step();
        step();
        chk_out("reset", 0, 0, 0);
        chk("reset.bs_out", int'(bs_out), 0);
        reset = 1'b0;

        // config chain: pattern then zeros; bs_out replays pattern after 23 cycles
        pat = 23'($urandom) | 23'h1;
        for (int j = 0; j < 23; j++) begin
            chk($sformatf("chain.fill%0d", j), int'(bs_out), 0);
            bs_in = pat[j];
            step();
        end
        for (int k = 0; k < 23; k++) begin
            chk($sformatf("chain.out%0d", k), int'(bs_out), int'(pat[k]));
            bs_in = 1'b0;
            step();
        end
        config_en = 1'b0;

        // table-driven vectors
        for (int t = 0; t < tv.size(); t++) begin
            if (tv[t].ld) load_cfg(tv[t].cfg);
            syn_in = tv[t].syn; clockbus = tv[t].cb; reset_nn = tv[t].nn;
            step();
            chk_out($sformatf("vec%0d", t), tv[t].mem, tv[t].ax, tv[t].sc);
        end
        reset_nn = 1'b0; clockbus = '0;

        // freeze during config: recirculate the chain for a full lap
        load_cfg(c1);
        reset_nn = 1'b1; step(); reset_nn = 1'b0;
        syn_in = 4'h1;
        step();
        step();
        chk_out("freeze.pre", 6, 0, 0);
        config_en = 1'b1;
        for (int k = 0; k < 23; k++) begin
            bs_in = bs_out;
            clockbus = 8'($urandom);
            step();
            chk_out($sformatf("freeze%0d", k), 6, 0, 0);
        end
        config_en = 1'b0; clockbus = '0;
        step();
        chk_out("freeze.resume", 0, 1, 1);

        // reset_nn during REFRACT keeps cfg
        load_cfg(c5);
        reset_nn = 1'b1; step(); reset_nn = 1'b0;
        syn_in = 4'h1;
        step();
        chk_out("rnn.fire", 0, 1, 1);
        reset_nn = 1'b1;
        step();
        chk_out("rnn.clear", 0, 0, 0);
        reset_nn = 1'b0;
        step();
        chk_out("rnn.integrate", 0, 1, 1);
        syn_in = 4'h0;
        config_en = 1'b1;
        for (int k = 0; k < 23; k++) begin
            chk($sformatf("rnn.cfg%0d", k), int'(bs_out), int'(c5[k]));
            bs_in = 1'b0;
            step();
        end
        config_en = 1'b0;
        chk_out("rnn.hold", 0, 0, 1);

        // spike counter saturation: cfg all zero => thr 0 fires every cycle
        reset_nn = 1'b1; step(); reset_nn = 1'b0;
        for (int n = 0; n < 254; n++) step();
        chk_out("sat.254", 0, 1, 254);
        step();
        chk_out("sat.255", 0, 1, 255);
        for (int n = 0; n < 5; n++) step();
        chk_out("sat.hold", 0, 1, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lif_neuron_cell.md
Name: lif_neuron_cell

Overview:
Parametrised leaky integrate-and-fire neuron. It is the next-generation configurable neuron block (CNB) for the neurochip array.
- Adds synaptic inputs with signed weights, a configurable firing threshold, saturating membrane arithmetic, refractory period, and a spike counter.
- Sits in the array alongside the clockbox. Receives the shared decay clockbus. Configured over the same serial bitstream chain (config_en / bs_in / bs_out) as existing cells.

Parameters:
N_IN, 4, number of synaptic inputs
W_BITS, 3, weight width (two's-complement, signed)
MP_BITS, 6, membrane potential and threshold width (unsigned)
N_CLK, 8, clockbus width
REFRAC_BITS, 2, refractory period field width
SEL_BITS, max(1,clog2(N_CLK)), decay select width (derived)
CFG_LEN, N_IN*W_BITS+MP_BITS+SEL_BITS+REFRAC_BITS, config chain length (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
reset_nn  in  1  network reset: clears dynamic state, keeps configuration
config_en  in  1  shift configuration chain when high
bs_in  in  1  configuration serial in
bs_out  out  1  configuration serial out (= cfg[0])
clockbus  in  N_CLK  decay strobes from clockbox
syn_in  in  N_IN  incoming spikes, one per synapse
axon  out  1  registered spike output
membrane  out  MP_BITS  current membrane potential (debug)
spike_count  out  8  saturating spike counter

Behaviour:
- Priority each posedge: reset > reset_nn > config_en > run.
- reset clears everything:
  - cfg = 0, membrane = 0, state = INTEGRATE, refrac counter = 0.
  - axon = 0, spike_count = 0.
- reset_nn clears dynamic state but keeps cfg:
  - membrane = 0, state = INTEGRATE, refrac counter = 0.
  - axon = 0, spike_count = 0.
- Config register:
  - config_en: cfg <= {bs_in, cfg[CFG_LEN-1:1]}; bs_out = cfg[0] combinationally. Chain delay is exactly CFG_LEN cycles.
  - During config_en, membrane, state, refrac counter and spike_count hold; axon = 0.
- Field map, LSB first:
  - w[i] = cfg[i*W_BITS +: W_BITS]
  - thr = next MP_BITS bits
  - dsel = next SEL_BITS bits
  - refrac = top REFRAC_BITS bits
  - The first bit shifted in ends at cfg[0].
- Run mode, state INTEGRATE:
  - sum = signed sum of w[i] for every i where syn_in[i] = 1. Use a width that cannot overflow (MP_BITS+W_BITS+clog2(N_IN)+1).
  - decay = clockbus[dsel] if dsel < N_CLK, else 0.
  - v_dec = decay ? membrane>>1 : membrane.
  - v_next = clamp(v_dec + sum, 0, 2^MP_BITS-1).
  - If v_next >= thr, the neuron fires (thr = 0 means fire every INTEGRATE cycle):
    - axon <= 1, membrane <= 0, spike_count <= min(spike_count+1, 255).
    - If refrac = 0, stay in INTEGRATE; else go to REFRACT with counter <= refrac.
  - Else: membrane <= v_next, axon <= 0.
- Run mode, state REFRACT:
  - syn_in and decay are ignored; membrane held at 0; axon <= 0.
  - counter decrements. When counter == 1, next state is INTEGRATE, so REFRACT lasts exactly refrac cycles.
- Timing:
  - axon is a one-cycle pulse, asserted in the cycle after the edge at which the threshold was crossed.
  - Minimum spike spacing is 1 + refrac cycles.
- Config changes take effect on the first run cycle after config_en drops.

Test Plan:
- Chain:
  - Stimulus: reset, shift a 23-bit random pattern with config_en=1 (defaults, CFG_LEN=23), then shift 23 zeros.
  - Required: bs_out replays the pattern bit-for-bit starting 23 cycles after its first bit; field decode matches the map.
- Integrate/fire:
  - Stimulus: w0=+3, thr=9, dsel=0 (clockbus[0]=0), refrac=0, syn_in=4'b0001 held.
  - Required: membrane 3, 6, then 0 with axon=1; axon pulses every 3rd cycle; spike_count increments per pulse.
- Inhibition/saturation:
  - Stimulus A: w1=-4 (3'b100), syn_in=4'b0010. Required: membrane stays 0, never negative.
  - Stimulus B: all w=+3, thr=63, syn_in=4'b1111. Required: membrane 12, 24, 36, 48, 60, then clamps to 63 → fires and membrane returns to 0.
- Leak:
  - Stimulus: dsel=1 with clockbus[1]=1, w0=+2, thr=63, syn_in=4'b0001.
  - Required: membrane 2, 3, 3, 3…; axon never asserts. Separately, dsel strobe low gives pure integration.
- Refractory:
  - Stimulus: w0=+3, thr=3, refrac=2, syn_in held.
  - Required: axon period 3 cycles. Pulsing syn_in during the 2 REFRACT cycles has no effect; membrane stays 0.
- Resets/freeze:
  - Stimulus: assert config_en mid-integration (membrane=6).
  - Required: membrane holds 6 and axon=0.
  - Stimulus: assert reset_nn during REFRACT.
  - Required: membrane=0, INTEGRATE, spike_count=0, cfg unchanged (bs_out chain intact).
  - Stimulus: spike_count reaching 255.
  - Required: it saturates at 255.
